// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. It decides the decode stall, the X
//            bubble and the X-stage operand forwarding selects.
// Config   : HAZARD_FORWARD_EN defined selects forwarding mode (load-use stalls
//            only). When undefined the block is interlock-only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_valid_i,
    input  logic [4:0]  d_rs1_i,
    input  logic [4:0]  d_rs2_i,
    input  logic        d_use_rs1_i,
    input  logic        d_use_rs2_i,
    input  logic [4:0]  d_rd_i,
    input  logic        d_regwe_i,
    input  logic        d_is_load_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        bubble_x_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic [15:0] stall_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwe;
        logic       is_load;
    } entry_t;

    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    entry_t      x_q, m_q, w_q, x_d;
    logic [4:0]  xs1_q, xs2_q;
    logic        xu1_q, xu2_q;
    logic [15:0] cnt_q, cnt_d;
    logic        hazard;
    logic        advance;
    logic        unused_bits;

    // x0 is hard-wired to zero, so it never creates a dependence.
    function automatic logic src_match(input logic use_src, input logic [4:0] addr,
                                       input entry_t e);
        return use_src && (addr != 5'd0) && e.valid && e.regwe && (e.rd == addr);
    endfunction

`ifdef HAZARD_FORWARD_EN
    localparam logic [1:0] FWD_M = 2'b01;
    localparam logic [1:0] FWD_W = 2'b10;

    // A load in M has no data yet, so only a W match can serve that operand.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] addr,
                                           input logic x_valid, input entry_t m,
                                           input entry_t w);
        if (!x_valid)
            return FWD_RF;
        if (src_match(use_src, addr, m) && !m.is_load)
            return FWD_M;
        if (src_match(use_src, addr, w))
            return FWD_W;
        return FWD_RF;
    endfunction

    assign unused_bits = w_q.is_load;
`else
    assign unused_bits = ^{xs1_q, xs2_q, xu1_q, xu2_q, x_q.is_load, m_q.is_load, w_q.is_load};
`endif

    always_comb begin
`ifdef HAZARD_FORWARD_EN
        hazard  = x_q.is_load & (src_match(d_use_rs1_i, d_rs1_i, x_q) |
                                 src_match(d_use_rs2_i, d_rs2_i, x_q));
        fwd_a_o = fwd_sel(xu1_q, xs1_q, x_q.valid, m_q, w_q);
        fwd_b_o = fwd_sel(xu2_q, xs2_q, x_q.valid, m_q, w_q);
`else
        hazard  = src_match(d_use_rs1_i, d_rs1_i, x_q) | src_match(d_use_rs2_i, d_rs2_i, x_q) |
                  src_match(d_use_rs1_i, d_rs1_i, m_q) | src_match(d_use_rs2_i, d_rs2_i, m_q) |
                  src_match(d_use_rs1_i, d_rs1_i, w_q) | src_match(d_use_rs2_i, d_rs2_i, w_q);
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
`endif
        // A flush kills the decode instruction, so it overrides any stall.
        stall_o    = hazard & d_valid_i & ~flush_i;
        bubble_x_o = stall_o | flush_i;
        advance    = d_valid_i & ~stall_o & ~flush_i;
        x_d        = {advance, d_rd_i, d_regwe_i, d_is_load_i};
        cnt_d      = (stall_o && (cnt_q != CNT_MAX)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            xs1_q <= '0;
            xs2_q <= '0;
            xu1_q <= 1'b0;
            xu2_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            w_q   <= m_q;
            m_q   <= x_q;
            x_q   <= x_d;
            xs1_q <= d_rs1_i;
            xs2_q <= d_rs2_i;
            xu1_q <= d_use_rs1_i;
            xu2_q <= d_use_rs2_i;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl; cycle vectors with expected
//            outputs, plus counter saturation and mid-stall reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        d_valid, d_use_rs1, d_use_rs2, d_regwe, d_is_load, flush;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        stall, bubble_x;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we, ld, fl;
        logic       st, bx;
        logic [1:0] fa, fb;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        st, bx;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_valid_i   (d_valid),
        .d_rs1_i     (d_rs1),
        .d_rs2_i     (d_rs2),
        .d_use_rs1_i (d_use_rs1),
        .d_use_rs2_i (d_use_rs2),
        .d_rd_i      (d_rd),
        .d_regwe_i   (d_regwe),
        .d_is_load_i (d_is_load),
        .flush_i     (flush),
        .stall_o     (stall),
        .bubble_x_o  (bubble_x),
        .fwd_a_o     (fwd_a),
        .fwd_b_o     (fwd_b),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run still active at time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic we, input logic ld, input logic fl,
                                input logic st, input logic bx, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [15:0] cnt);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
        t.we = we; t.ld = ld; t.fl = fl; t.st = st; t.bx = bx; t.fa = fa; t.fb = fb;
        t.cnt = cnt;
        return t;
    endfunction

    task automatic vec(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl,
                       input logic st, input logic bx, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [15:0] cnt);
        tbl.push_back(mk(v, rs1, u1, rs2, u2, rd, we, ld, fl, st, bx, fa, fb, cnt));
    endtask

    task automatic drive(input vec_t t);
        d_valid = t.v; d_rs1 = t.rs1; d_use_rs1 = t.u1; d_rs2 = t.rs2; d_use_rs2 = t.u2;
        d_rd = t.rd; d_regwe = t.we; d_is_load = t.ld; flush = t.fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_table(input string tag);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e.st = tbl[i].st; e.bx = tbl[i].bx; e.fa = tbl[i].fa; e.fb = tbl[i].fb;
            e.cnt = tbl[i].cnt;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk($sformatf("%s%0d.scoreboard_empty", tag, i), 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s%0d.stall", tag, i), {15'd0, stall}, {15'd0, e.st});
                chk($sformatf("%s%0d.bubble_x", tag, i), {15'd0, bubble_x}, {15'd0, e.bx});
                chk($sformatf("%s%0d.fwd_a", tag, i), {14'd0, fwd_a}, {14'd0, e.fa});
                chk($sformatf("%s%0d.fwd_b", tag, i), {14'd0, fwd_b}, {14'd0, e.fb});
                chk($sformatf("%s%0d.stall_cnt", tag, i), stall_cnt, e.cnt);
            end
            tick();
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst.stall", {15'd0, stall}, 16'd0);
        chk("rst.bubble_flush", {15'd0, bubble_x}, 16'd1);
        chk("rst.fwd_a", {14'd0, fwd_a}, 16'd0);
        chk("rst.fwd_b", {14'd0, fwd_b}, 16'd0);
        chk("rst.stall_cnt", stall_cnt, 16'd0);
        flush = 1'b0;
        #1;
        chk("rst.bubble_noflush", {15'd0, bubble_x}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic reset_mid_stall(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_stall"}, {15'd0, stall}, 16'd0);
        chk({tag, ".rst_bubble"}, {15'd0, bubble_x}, 16'd0);
        chk({tag, ".rst_cnt"}, stall_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2;
        do_reset();
`ifdef HAZARD_FORWARD_EN
        vec(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);  // add x5,x1,x2
        vec(1, 5, 1, 1, 1, 6, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);  // add x6,x5,x1
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b00, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        vec(1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);  // lw x7
        vec(1, 7, 1, 7, 1, 8, 1, 0, 0,  1, 1, 2'b00, 2'b00, 0);  // add x8,x7,x7
        vec(1, 7, 1, 7, 1, 8, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 2'b10, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        vec(1, 1, 1, 2, 1, 0, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x0
        vec(1, 0, 1, 0, 1, 3, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x3,x0,x0
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        vec(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x5 (older)
        vec(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x5 (younger)
        vec(1, 5, 1, 5, 1, 6, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x6,x5,x5
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b01, 1);  // M beats W
        vec(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x5
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        vec(1, 1, 1, 5, 1, 6, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1);  // add x6,x1,x5
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b10, 1);  // W only
        vec(1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 2'b00, 2'b00, 1);  // lw x7
        vec(1, 7, 1, 7, 1, 8, 1, 0, 1,  0, 1, 2'b00, 2'b00, 1);  // flush in hazard cycle
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00, 1);
        apply_table("fwd");

        // Mid-stall reset with a nonzero count.
        do_reset();
        drive(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0)); tick();
        drive(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0)); tick(); tick();
        drive(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0)); tick();
        drive(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("mid.stall", {15'd0, stall}, 16'd1);
        chk("mid.cnt", stall_cnt, 16'd1);
        reset_mid_stall("mid");
`else
        vec(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);  // add x5,x1,x2
        vec(1, 2, 1, 5, 1, 9, 1, 0, 0,  1, 1, 2'b00, 2'b00, 0);  // sub x9,x2,x5
        vec(1, 2, 1, 5, 1, 9, 1, 0, 0,  1, 1, 2'b00, 2'b00, 1);
        vec(1, 2, 1, 5, 1, 9, 1, 0, 0,  1, 1, 2'b00, 2'b00, 2);
        vec(1, 2, 1, 5, 1, 9, 1, 0, 0,  0, 0, 2'b00, 2'b00, 3);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3);
        vec(1, 1, 1, 2, 1, 0, 1, 0, 0,  0, 0, 2'b00, 2'b00, 3);  // add x0
        vec(1, 0, 1, 0, 1, 3, 1, 0, 0,  0, 0, 2'b00, 2'b00, 3);  // add x3,x0,x0
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3);
        vec(1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 2'b00, 2'b00, 3);  // lw x7
        vec(1, 7, 1, 7, 1, 8, 1, 0, 1,  0, 1, 2'b00, 2'b00, 3);  // flush in hazard cycle
        vec(1, 7, 0, 7, 0, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3);  // sources not used
        vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00, 3);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3);
        apply_table("ilk");

        // Self-dependent chain: each link stalls 3 cycles then advances.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0)); tick();
        drive(mk(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 21845; k++) begin
            repeat (4) tick();
            if (k == 9) begin
                @(negedge clk);
                chk("sat.cnt30", stall_cnt, 16'd30);
            end
        end
        @(negedge clk);
        chk("sat.cnt_max", stall_cnt, 16'hFFFF);
        chk("sat.stall_a", {15'd0, stall}, 16'd1);
        tick();
        @(negedge clk);
        chk("sat.cnt_hold", stall_cnt, 16'hFFFF);
        chk("sat.stall_b", {15'd0, stall}, 16'd1);
        reset_mid_stall("sat");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 d_valid  in  1  decode stage holds a real instruction.
REQ-003 d_rs1, d_rs2  in  5 each  decode-stage source register addresses.
REQ-004 d_use_rs1, d_use_rs2  in  1 each  decode instruction reads that source.
REQ-005 d_rd  in  5  decode destination address; d_regwe  in  1  decode writes rd; d_is_load  in  1  decode instruction is a load.
REQ-006 flush  in  1  taken branch/jump resolved this cycle; kill the decode instruction.
REQ-007 stall  out  1  hold PC and the F/D register this cycle.
REQ-008 bubble_x  out  1  load a NOP into the D/X register this cycle.
REQ-009 fwd_a, fwd_b  out  2 each  X-stage operand source: 00 regfile, 01 M-stage ALU result, 10 W-stage writeback value, 11 unused.
REQ-010 stall_cnt  out  16  saturating count of stall cycles since reset.

Function
REQ-011 The block SHALL keep shadow entries X, M and W, each holding {valid, rd, regwe, is_load}; the X entry also holds rs1, rs2, use_rs1 and use_rs2.
REQ-012 Every rising edge: W<=M; M<=X; X<=D-entry when the D instruction advances, else X<=invalid.
REQ-013 The D instruction SHALL advance when d_valid=1, stall=0 and flush=0.
REQ-014 A source SHALL match an entry only when use=1, address!=0, entry.valid=1, entry.regwe=1 and entry.rd equals the address; x0 never matches.
REQ-015 stall and bubble_x SHALL be combinational, with bubble_x = (stall | flush) and stall = hazard & d_valid & !flush; flush SHALL override stall.
REQ-016 fwd_a/fwd_b SHALL be combinational from the X entry: 01 when the source matches M and M.is_load=0; else 10 when it matches W; else 00. M has priority over W.
REQ-017 stall_cnt SHALL increment by 1 on every rising edge with stall=1 and hold at 16'hFFFF.
REQ-018 A simultaneous flush and hazard SHALL produce no stall and no count increment.
REQ-019 A stall lasting N cycles SHALL insert exactly N bubbles into X, and the stalled instruction SHALL enter X on the first non-stalled edge.

Reset
REQ-020 While rst_n=0, all shadow entries SHALL be invalid and stall_cnt SHALL be 0, so stall=0, fwd_a=fwd_b=00 and bubble_x=flush.
REQ-021 Reset asserted mid-stall SHALL clear the stall immediately, without waiting for a clock edge.
REQ-022 The first edge after deassertion SHALL perform normal advancement.

Configuration
REQ-023 Macro HAZARD_FORWARD_EN, when defined, SHALL select forwarding mode.
- hazard = a D source matches X with X.is_load=1 (load-use), giving 1 stall cycle per dependent load.
- fwd_a/fwd_b operate per REQ-016.
REQ-024 When HAZARD_FORWARD_EN is undefined, the block SHALL operate in interlock-only mode.
- hazard = a D source matches X, M or W.
- fwd_a and fwd_b are tied to 00.
- A back-to-back dependence stalls 3 cycles.

Verification
REQ-025 HAZARD_FORWARD_EN defined. Stimulus: add x5 then add x6,x5,x1 on consecutive cycles -> stall never 1; fwd_a=01 while the second add is in X.
REQ-026 HAZARD_FORWARD_EN defined. Stimulus: lw x7 then add x8,x7,x7 -> stall=1 and bubble_x=1 for exactly 1 cycle; fwd_a=fwd_b=10 when the add reaches X; stall_cnt=1.
REQ-027 HAZARD_FORWARD_EN undefined. Stimulus: add x5 then sub x9,x2,x5 -> stall=1 for 3 consecutive cycles; stall_cnt=3; fwd_b stays 00.
REQ-028 Stimulus: writer to x0 followed by a reader of x0 -> stall=0 and fwd=00 in both modes.
REQ-029 Stimulus: lw x7 then dependent add, with flush=1 in the hazard cycle -> stall=0, bubble_x=1, stall_cnt unchanged.
REQ-030 Stimulus: hold a load-use dependence with a persistent stall source until stall_cnt=16'hFFFF, then add one more stall cycle -> stall_cnt stays FFFF; then rst_n=0 mid-stall -> stall=0 and stall_cnt=0 before the next edge.
